// File: rtl/decimal_merge.sv
`default_nettype none
// ============================================================================
// decimal_merge : sequential two-digit BCD to binary converter (adds 10/clock)
// Rev 1.0
// ============================================================================
module decimal_merge #(
  parameter int NUM_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       dec_i,
  input  logic [3:0]       unit_i,
  output logic [NUM_W-1:0] number_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [7:0] C_MAX = 8'((1 << NUM_W) - 1);

  state_t           state_q;
  logic [6:0]       acc_q;
  logic [3:0]       cnt_q;
  logic [NUM_W-1:0] number_q;
  logic             err_q;
  logic [7:0]       w_acc_ext;

  // Widened so both the saturation compare and the slice stay legal up to NUM_W=8.
  assign w_acc_ext = {1'b0, acc_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      number_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if ((dec_i <= 4'd9) && (unit_i <= 4'd9)) begin
              acc_q   <= {3'b000, unit_i};
              cnt_q   <= dec_i;
              state_q <= ACCUM;
            end else begin
              number_q <= '0;
              err_q    <= 1'b1;
              state_q  <= FINISH;
            end
          end
        end
        ACCUM: begin
          if (cnt_q != 4'd0) begin
            acc_q <= acc_q + 7'd10;
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (w_acc_ext <= C_MAX) begin
              number_q <= w_acc_ext[NUM_W-1:0];
              err_q    <= 1'b0;
            end else begin
              number_q <= '1;
              err_q    <= 1'b1;
            end
            state_q <= FINISH;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign number_o = number_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_decimal_merge.sv
`default_nettype none
// ============================================================================
// tb_decimal_merge : scoreboard bench for decimal_merge (NUM_W = 5)
// Rev 1.0
// ============================================================================
module tb_decimal_merge;

  localparam int NUM_W = 5;
  localparam int C_MAX = (1 << NUM_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [3:0]       dec_i = 4'd0;
  logic [3:0]       unit_i = 4'd0;
  logic [NUM_W-1:0] number_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  typedef struct {
    int num;
    int err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  decimal_merge #(.NUM_W(NUM_W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .dec_i    (dec_i),
    .unit_i   (unit_i),
    .number_o (number_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Result checker: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      check("sb_pending", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("number", int'(number_o), mon_e.num);
        check("err", int'(err_o), mon_e.err);
      end
    end
  end

  task automatic convert(input logic [3:0] d, input logic [3:0] u, input bit disturb);
    exp_t e;
    int   v;
    int   n;
    int   nb;
    int   exp_lat;
    if (d > 9 || u > 9) begin
      e.num = 0; e.err = 1; exp_lat = 0;
    end else begin
      v = int'(d) * 10 + int'(u);
      exp_lat = int'(d) + 1;
      if (v > C_MAX) begin e.num = C_MAX; e.err = 1; end
      else           begin e.num = v;     e.err = 0; end
    end
    @(negedge clk);
    dec_i = d; unit_i = u; start_i = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start_i = 1'b0;
    if (disturb) begin
      start_i = 1'b1; dec_i = 4'd9; unit_i = 4'd9;
    end
    n = 0; nb = 0;
    while (!done_o && n < 20) begin
      if (busy_o) nb++;
      @(posedge clk); #1;
      n++;
      if (disturb && n == 1) begin
        start_i = 1'b0; dec_i = 4'd0; unit_i = 4'd0;
      end
    end
    if (busy_o) nb++;
    check("latency", n, exp_lat);
    check("busy_cycles", nb, exp_lat + 1);
    @(posedge clk); #1;
    check("done_pulse", int'(done_o), 0);
    check("busy_idle", int'(busy_o), 0);
    check("number_hold", int'(number_o), e.num);
  endtask

  initial begin
    #2;
    check("rst_number", int'(number_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    @(negedge clk);
    rst = 1'b0;

    convert(4'd2,  4'd7,  1'b0);
    convert(4'd0,  4'd0,  1'b0);
    convert(4'd3,  4'd5,  1'b0);
    convert(4'd3,  4'd1,  1'b0);
    convert(4'd4,  4'd10, 1'b0);
    convert(4'd2,  4'd7,  1'b1);
    convert(4'd12, 4'd3,  1'b0);
    convert(4'd9,  4'd9,  1'b0);
    convert(4'd3,  4'd1,  1'b0);

    // Asynchronous reset in the middle of a long conversion.
    @(negedge clk);
    dec_i = 4'd9; unit_i = 4'd0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_number", int'(number_o), 0);
    check("async_err", int'(err_o), 0);
    check("async_busy", int'(busy_o), 0);
    check("async_done", int'(done_o), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("no_done_after_rst", int'(busy_o), 0);

    convert(4'd1, 4'd9, 1'b0);
    convert(4'd5, 4'd8, 1'b0);
    for (int i = 0; i < 6; i++) begin
      convert(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
